dmux8way_seq: RTL and testbench
===============================

Name: dmux8way_seq

Overview:
Upstream sequencer for dmux8way. It accepts (dado, destino) words over a valid/ready handshake and buffers them in a small FIFO. It drives entrada/sel of dmux8way one word at a time for a fixed hold window, with a mandatory idle gap between words. It also keeps a count of delivered words.

Parameters:
WIDTH, 4, data width; must match dmux8way entrada.
DEPTH, 4, FIFO depth in words; power of 2, at least 2.
HOLD, 2, cycles each word is driven on entrada/sel; at least 1.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  producer has a word on in_dado/in_destino.
in_ready  output  1  block can accept a word.
in_dado  input  WIDTH  data to deliver.
in_destino  input  3  target output index 0..7.
entrada  output  WIDTH  to dmux8way entrada; registered.
sel  output  3  to dmux8way sel; registered.
ativo  output  1  high while a word is being driven; registered.
vazio  output  1  FIFO count == 0.
cheio  output  1  FIFO count == DEPTH.
entregas  output  8  number of completed deliveries; wraps modulo 256.

Behaviour:
Interface:
- One clock, clk.
- Reset is synchronous and active-low on rst_n.
- While rst_n=0, at every rising edge: entrada=0, sel=0, ativo=0, entregas=0, FIFO count=0 (contents discarded), FSM=IDLE.

Handshake and flags:
- in_ready = rst_n & ~cheio (combinational).
- A push occurs at an edge where in_valid & in_ready.
- No bypass: a full FIFO refuses input even if a pop happens in the same cycle.
- vazio and cheio are combinational from the FIFO count.

FIFO:
- Circular buffer with log2(DEPTH)-bit read/write pointers; pointers wrap from DEPTH-1 to 0.
- Count width is log2(DEPTH)+1.
- Push and pop at the same edge: both take effect, count unchanged.

FSM states:
- IDLE:
  - If count>0: pop head; entrada<=dado, sel<=destino, ativo<=1, hold counter<=HOLD-1; go DRIVE.
  - Otherwise stay IDLE.
- DRIVE:
  - If counter>0: decrement.
  - If counter==0: entrada<=0, ativo<=0, entregas<=entregas+1; go GAP.
- GAP:
  - Exactly one cycle with entrada=0; sel keeps its last value.
  - If count>0: pop and load as in IDLE; go DRIVE.
  - Otherwise go IDLE.

Timing and invariants:
- Latency: a word pushed into an empty, IDLE block at edge t appears on entrada/sel with ativo=1 from edge t+1.
- That word is held for exactly HOLD cycles; entrada returns to 0 at edge t+1+HOLD.
- Back-to-back words: HOLD cycles active, 1 cycle gap, repeat.
- entrada is 0 whenever ativo=0, so all dmux8way outputs are 0 outside the drive window.
- sel changes only on the edge that loads a new word (or on reset).
- entregas increments once per word, on the DRIVE->GAP edge; it wraps 255->0.
- in_dado/in_destino are sampled only on a push edge; they are don't-care otherwise.
- Reset mid-DRIVE: the word in flight is not counted; buffered words are lost.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, no push, entrada=0, sel=0, ativo=0, vazio=1, entregas=0.
- Single word (HOLD=2): push dado=4'b0001, destino=3 at edge t -> at t+1 and t+2: ativo=1, sel=3, entrada=1; at t+3: entrada=0, ativo=0, entregas=1; then IDLE with vazio=1.
- Burst: hold in_valid=1 and push destino 0..7 (dado=1) as fast as in_ready allows, DEPTH=4.
  - in_ready drops when cheio=1.
  - sel runs 0,1,...,7 in order, each active 2 cycles with a 1-cycle gap of entrada=0.
  - Final entregas=8; no word lost or duplicated.
- Simultaneous push/pop: with count=2, push in the same cycle the GAP state pops -> count stays 2, delivery order is preserved.
- Reset mid-operation: with 3 words queued and DRIVE active, pulse rst_n=0 for one cycle -> next edge entrada=0, ativo=0, vazio=1, entregas=0; no further deliveries without new pushes.
- Counter wrap: deliver 256 words -> entregas reads 255 after the 255th and 0 after the 256th.

Source files
------------

// File: rtl/dmux8way_seq_if.sv
// Word-delivery bus between a producer, the dmux8way_seq sequencer and a dmux8way.
// The sequencer takes the slave modport; the producer/observer takes master.
interface dmux8way_seq_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dado;
  logic [2:0]       in_destino;
  logic [WIDTH-1:0] entrada;
  logic [2:0]       sel;
  logic             ativo;
  logic             vazio;
  logic             cheio;
  logic [7:0]       entregas;

  modport master (
    output in_valid, in_dado, in_destino,
    input  in_ready, entrada, sel, ativo, vazio, cheio, entregas
  );

  modport slave (
    input  in_valid, in_dado, in_destino,
    output in_ready, entrada, sel, ativo, vazio, cheio, entregas
  );
endinterface

// File: rtl/dmux8way_seq.sv
// Sequencer feeding dmux8way: buffers (dado, destino) words in a small FIFO and
// drives each one on entrada/sel for HOLD cycles, followed by a one-cycle idle gap.
module dmux8way_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int HOLD  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  dmux8way_seq_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int EW = WIDTH + 3;

  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [EW-1:0]    mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;

  logic [HW-1:0]    hold_reg, hold_next;
  logic [WIDTH-1:0] entrada_reg, entrada_next;
  logic [2:0]       sel_reg, sel_next;
  logic             ativo_reg, ativo_next;
  logic [7:0]       entregas_reg, entregas_next;

  logic             vazio, cheio, in_ready;
  logic             push, pop;
  logic [EW-1:0]    head;
  logic [WIDTH-1:0] head_dado;
  logic [2:0]       head_destino;

  // Flags come straight from the occupancy count; a full FIFO never accepts,
  // even on a cycle where the FSM pops.
  assign vazio    = (count_reg == '0);
  assign cheio    = (count_reg == DEPTH_C);
  assign in_ready = rst_n & ~cheio;
  assign push     = bus.in_valid & in_ready;

  assign head         = mem_reg[rd_ptr_reg];
  assign head_dado    = head[WIDTH-1:0];
  assign head_destino = head[EW-1:WIDTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= {bus.in_destino, bus.in_dado};
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // IDLE and GAP share the load path; they differ only in how they were entered.
  always_comb begin
    state_next    = state_reg;
    hold_next     = hold_reg;
    entrada_next  = entrada_reg;
    sel_next      = sel_reg;
    ativo_next    = ativo_reg;
    entregas_next = entregas_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE, GAP: begin
        if (!vazio) begin
          pop          = 1'b1;
          entrada_next = head_dado;
          sel_next     = head_destino;
          ativo_next   = 1'b1;
          hold_next    = HOLD_LOAD;
          state_next   = DRIVE;
        end else begin
          state_next = IDLE;
        end
      end
      DRIVE: begin
        if (hold_reg != '0) begin
          hold_next = hold_reg - HW'(1);
        end else begin
          entrada_next  = '0;
          ativo_next    = 1'b0;
          entregas_next = entregas_reg + 8'd1;
          state_next    = GAP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      hold_reg     <= '0;
      entrada_reg  <= '0;
      sel_reg      <= '0;
      ativo_reg    <= 1'b0;
      entregas_reg <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      hold_reg     <= hold_next;
      entrada_reg  <= entrada_next;
      sel_reg      <= sel_next;
      ativo_reg    <= ativo_next;
      entregas_reg <= entregas_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.entrada  = entrada_reg;
  assign bus.sel      = sel_reg;
  assign bus.ativo    = ativo_reg;
  assign bus.vazio    = vazio;
  assign bus.cheio    = cheio;
  assign bus.entregas = entregas_reg;

endmodule

// File: tb/tb_dmux8way_seq.sv
// Bench for dmux8way_seq: vector table, directed multi-cycle sequences and
// randomized traffic, all checked against a schedule-based reference model.
module tb_dmux8way_seq;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int HOLD  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmux8way_seq_if #(.WIDTH(WIDTH)) bus ();

  dmux8way_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] dado;
    logic [2:0] dest;
  } word_t;

  // Reference model: a word is popped at max(push edge + 1, previous pop + HOLD + 1),
  // is active for HOLD edges and is counted as delivered HOLD edges after its pop.
  word_t      m_q[$];
  bit         m_active = 1'b0;
  int         m_start = 0;
  int         m_next_free = 0;
  int         m_edge = 0;
  logic [3:0] m_dado = '0;
  logic [2:0] m_sel = '0;
  int         m_ent = 0;

  word_t obs_q[$];
  logic  prev_ativo = 1'b0;
  bit    saw_cheio = 1'b0;

  typedef struct {
    logic       r;
    logic       v;
    logic [3:0] d;
    logic [2:0] s;
    logic       e_ready;
    logic [3:0] e_ent;
    logic [2:0] e_sel;
    logic       e_ativo;
    logic       e_vazio;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic p, input word_t w);
    word_t h;
    m_edge++;
    if (!r) begin
      m_q.delete();
      m_active    = 1'b0;
      m_sel       = '0;
      m_dado      = '0;
      m_ent       = 0;
      m_next_free = m_edge + 1;
    end else begin
      if (m_active && m_edge == m_start + HOLD) begin
        m_active = 1'b0;
        m_ent    = (m_ent + 1) % 256;
      end
      if (m_q.size() != 0 && m_edge >= m_next_free) begin
        h           = m_q.pop_front();
        m_active    = 1'b1;
        m_start     = m_edge;
        m_next_free = m_edge + HOLD + 1;
        m_sel       = h.dest;
        m_dado      = h.dado;
      end
      if (p) m_q.push_back(w);
    end
  endtask

  // One clock cycle: drive at the falling edge, check in_ready, clock, check outputs.
  task automatic step(input logic r, input logic v, input logic [3:0] d, input logic [2:0] s,
                      output logic pushed, output logic rdy);
    word_t w;
    logic  exp_ready;
    rst_n          = r;
    bus.in_valid   = v;
    bus.in_dado    = d;
    bus.in_destino = s;
    #1;
    exp_ready = r && (m_q.size() < DEPTH);
    rdy = bus.in_ready;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    pushed = v && exp_ready;
    w.dado = d;
    w.dest = s;
    @(posedge clk);
    model_edge(r, pushed, w);
    @(negedge clk);
    chk("entrada", 32'(bus.entrada), 32'(m_active ? m_dado : 4'd0));
    chk("sel", 32'(bus.sel), 32'(m_sel));
    chk("ativo", 32'(bus.ativo), 32'(m_active));
    chk("vazio", 32'(bus.vazio), 32'(m_q.size() == 0));
    chk("cheio", 32'(bus.cheio), 32'(m_q.size() == DEPTH));
    chk("entregas", 32'(bus.entregas), 32'(m_ent));
    if (bus.ativo === 1'b1 && prev_ativo !== 1'b1) begin
      w.dado = bus.entrada;
      w.dest = bus.sel;
      obs_q.push_back(w);
    end
    prev_ativo = bus.ativo;
    if (bus.cheio === 1'b1) saw_cheio = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p, rd;
    int   idx, cyc;
    bit   saw255;

    vt[0] = '{1'b0, 1'b1, 4'hF, 3'd7, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 8'd0};
    vt[1] = '{1'b0, 1'b1, 4'hF, 3'd7, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 8'd0};
    vt[2] = '{1'b1, 1'b1, 4'h1, 3'd3, 1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 8'd0};
    vt[3] = '{1'b1, 1'b0, 4'h0, 3'd0, 1'b1, 4'd1, 3'd3, 1'b1, 1'b1, 8'd0};
    vt[4] = '{1'b1, 1'b0, 4'h0, 3'd0, 1'b1, 4'd1, 3'd3, 1'b1, 1'b1, 8'd0};
    vt[5] = '{1'b1, 1'b0, 4'h0, 3'd0, 1'b1, 4'd0, 3'd3, 1'b0, 1'b1, 8'd1};
    vt[6] = '{1'b1, 1'b0, 4'h0, 3'd0, 1'b1, 4'd0, 3'd3, 1'b0, 1'b1, 8'd1};

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_dado    = '0;
    bus.in_destino = '0;
    @(negedge clk);

    // Reset with in_valid high, then a single word with HOLD=2.
    for (int i = 0; i < 7; i++) begin
      step(vt[i].r, vt[i].v, vt[i].d, vt[i].s, p, rd);
      chk("vec_ready", 32'(rd), 32'(vt[i].e_ready));
      chk("vec_entrada", 32'(bus.entrada), 32'(vt[i].e_ent));
      chk("vec_sel", 32'(bus.sel), 32'(vt[i].e_sel));
      chk("vec_ativo", 32'(bus.ativo), 32'(vt[i].e_ativo));
      chk("vec_vazio", 32'(bus.vazio), 32'(vt[i].e_vazio));
      chk("vec_entregas", 32'(bus.entregas), 32'(vt[i].e_cnt));
      $display("vec %0d: ready=%0b entrada=%0d sel=%0d ativo=%0b vazio=%0b entregas=%0d",
               i, rd, bus.entrada, bus.sel, bus.ativo, bus.vazio, bus.entregas);
    end

    // Burst of eight words to destinations 0..7.
    step(1'b0, 1'b0, 4'd0, 3'd0, p, rd);
    obs_q.delete();
    saw_cheio = 1'b0;
    idx = 0;
    cyc = 0;
    while (cyc < 200 && !(idx == 8 && m_q.size() == 0 && !m_active)) begin
      step(1'b1, idx < 8, 4'd1, 3'(idx), p, rd);
      if (p) idx++;
      cyc++;
    end
    chk("burst_done_in_budget", 32'(cyc < 200), 32'd1);
    chk("burst_entregas", 32'(bus.entregas), 32'd8);
    chk("burst_words", 32'(obs_q.size()), 32'd8);
    chk("burst_cheio_seen", 32'(saw_cheio), 32'd1);
    for (int i = 0; i < obs_q.size(); i++) begin
      chk("burst_sel_order", 32'(obs_q[i].dest), 32'(i));
      chk("burst_dado", 32'(obs_q[i].dado), 32'd1);
    end
    $display("burst: %0d words delivered, entregas=%0d, cycles=%0d", obs_q.size(), bus.entregas, cyc);

    // Push landing on the same edge as a GAP pop while two words are buffered.
    step(1'b0, 1'b0, 4'd0, 3'd0, p, rd);
    obs_q.delete();
    step(1'b1, 1'b1, 4'd2, 3'd1, p, rd);
    step(1'b1, 1'b1, 4'd3, 3'd2, p, rd);
    step(1'b1, 1'b1, 4'd4, 3'd5, p, rd);
    step(1'b1, 1'b0, 4'd0, 3'd0, p, rd);
    chk("pp_count_before", 32'(m_q.size()), 32'd2);
    step(1'b1, 1'b1, 4'd5, 3'd6, p, rd);
    chk("pp_count_after", 32'(m_q.size()), 32'd2);
    chk("pp_second_word_sel", 32'(bus.sel), 32'd2);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 4'd0, 3'd0, p, rd);
    chk("pp_words", 32'(obs_q.size()), 32'd4);
    for (int i = 0; i < obs_q.size(); i++) chk("pp_order", 32'(obs_q[i].dado), 32'(i + 2));
    $display("push_pop: %0d words delivered, entregas=%0d", obs_q.size(), bus.entregas);

    // Reset in the middle of a DRIVE window with three words queued.
    step(1'b0, 1'b0, 4'd0, 3'd0, p, rd);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'(i + 7), 3'(i), p, rd);
    chk("mid_ativo_before", 32'(bus.ativo), 32'd1);
    chk("mid_queued_before", 32'(m_q.size()), 32'd3);
    step(1'b0, 1'b0, 4'd0, 3'd0, p, rd);
    chk("mid_entrada", 32'(bus.entrada), 32'd0);
    chk("mid_ativo", 32'(bus.ativo), 32'd0);
    chk("mid_vazio", 32'(bus.vazio), 32'd1);
    chk("mid_entregas", 32'(bus.entregas), 32'd0);
    obs_q.delete();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'd0, 3'd0, p, rd);
    chk("mid_no_delivery", 32'(obs_q.size()), 32'd0);
    chk("mid_entregas_idle", 32'(bus.entregas), 32'd0);
    $display("reset_mid: entregas=%0d vazio=%0b", bus.entregas, bus.vazio);

    // 256 deliveries: entregas reaches 255 then wraps to 0.
    step(1'b0, 1'b0, 4'd0, 3'd0, p, rd);
    obs_q.delete();
    idx = 0;
    cyc = 0;
    saw255 = 1'b0;
    while (cyc < 1200 && !(idx == 256 && m_q.size() == 0 && !m_active)) begin
      step(1'b1, idx < 256, 4'($urandom_range(1, 15)), 3'($urandom_range(0, 7)), p, rd);
      if (p) idx++;
      if (bus.entregas === 8'd255) saw255 = 1'b1;
      cyc++;
    end
    chk("wrap_done_in_budget", 32'(cyc < 1200), 32'd1);
    chk("wrap_saw_255", 32'(saw255), 32'd1);
    chk("wrap_entregas", 32'(bus.entregas), 32'd0);
    chk("wrap_words", 32'(obs_q.size()), 32'd256);
    $display("wrap: %0d words delivered, entregas=%0d", obs_q.size(), bus.entregas);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0,
           4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), p, rd);
    end
    $display("random: 3000 cycles, entregas=%0d", bus.entregas);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
